// File: rtl/ram_1c_1r_1w_pipe_pkg.sv
// Shared types and helpers for the single-clock byte-enable RAM.
package ram_pkg;

    typedef enum int unsigned {
        COLL_WRITE_FIRST = 0,
        COLL_REPORT      = 1
    } coll_mode_e;

    // Address width for a given depth; a depth of 1 still gets one address bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_1c_1r_1w_pipe_core.sv
// Plain storage array: per-lane write, one registered read, no reset and no
// bypass so that the array maps onto a vendor block RAM.
module ram_core_be #(
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumBytes  = 4,
    parameter int unsigned Depth     = 1024,
    parameter int unsigned AddrW     = 10,
    parameter int unsigned Width     = ByteWidth * NumBytes
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [NumBytes-1:0]  wr_be,
    input  logic [AddrW-1:0]     wr_addr,
    input  logic [Width-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [AddrW-1:0]     rd_addr,
    output logic [Width-1:0]     rd_data
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rd_data_q;

    // Lane-masked write and read-before-write registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(NumBytes); i++) begin
                if (wr_be[i]) mem_q[wr_addr][i*ByteWidth +: ByteWidth] <= wr_data[i*ByteWidth +: ByteWidth];
            end
        end
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_1c_1r_1w_pipe.sv
// Simple dual-port byte-enable RAM with read-valid pipeline, write-first
// collision bypass, address range checking and optional output register.
module ram_1c_1r_1w_pipe
    import ram_pkg::*;
#(
    parameter  int unsigned ByteWidth     = 8,
    parameter  int unsigned NumBytes      = 4,
    parameter  int unsigned Depth         = 1024,
    parameter  int unsigned ReadLatency   = 1,
    parameter  int unsigned CollisionMode = 0,
    localparam int unsigned Width         = ByteWidth * NumBytes,
    localparam int unsigned AddrW         = clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [NumBytes-1:0] wr_be,
    input  logic [AddrW-1:0]    wr_addr,
    input  logic [Width-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [AddrW-1:0]    rd_addr,
    output logic                rd_valid,
    output logic [Width-1:0]    rd_data
);

    if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
        $fatal(1, "ram_1c_1r_1w_pipe: ReadLatency must be 1 or 2");
    end
    if (CollisionMode != COLL_WRITE_FIRST && CollisionMode != COLL_REPORT) begin : g_bad_mode
        $fatal(1, "ram_1c_1r_1w_pipe: CollisionMode must be 0 or 1");
    end

    logic                wr_in_range;
    logic                rd_in_range;
    logic                coll;
    logic [Width-1:0]    ram_rd_data;

    logic                s1_valid_q;
    logic                s1_live_q;   // at least one read since reset; gates the unreset RAM register
    logic                s1_coll_q;
    logic                s1_oor_q;
    logic [NumBytes-1:0] s1_wbe_q;
    logic [Width-1:0]    s1_wdata_q;
    logic [Width-1:0]    s1_data_d;

    assign wr_in_range = 32'(wr_addr) < Depth;
    assign rd_in_range = 32'(rd_addr) < Depth;
    assign coll        = rd_en && wr_en && (rd_addr == wr_addr);

    ram_core_be #(
        .ByteWidth (ByteWidth),
        .NumBytes  (NumBytes),
        .Depth     (Depth),
        .AddrW     (AddrW),
        .Width     (Width)
    ) u_core (
        .clk     (clk),
        .wr_en   (wr_en && wr_in_range),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Stage 1: read valid plus collision/range side information captured with the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_live_q  <= 1'b0;
            s1_coll_q  <= 1'b0;
            s1_oor_q   <= 1'b0;
            s1_wbe_q   <= '0;
            s1_wdata_q <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_live_q  <= 1'b1;
                s1_coll_q  <= coll;
                s1_oor_q   <= !rd_in_range;
                s1_wbe_q   <= wr_be;
                s1_wdata_q <= wr_data;
            end
        end
    end

    // Merge captured write lanes over the RAM word on a collision; out-of-range reads return zero.
    always_comb begin
        s1_data_d = ram_rd_data;
        for (int i = 0; i < int'(NumBytes); i++) begin
            if (s1_coll_q && s1_wbe_q[i]) s1_data_d[i*ByteWidth +: ByteWidth] = s1_wdata_q[i*ByteWidth +: ByteWidth];
        end
`ifndef SYNTHESIS
        if (CollisionMode == COLL_REPORT && s1_coll_q) s1_data_d = 'x;
`endif
        if (s1_oor_q) s1_data_d = '0;
        if (!s1_live_q) s1_data_d = '0;
    end

    if (ReadLatency == 2) begin : g_out_reg
        logic             s2_valid_q;
        logic [Width-1:0] s2_data_q;

        // Stage 2: output register loaded only by a valid stage-1 result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_d;
            end
        end

        assign rd_valid = s2_valid_q;
        assign rd_data  = s2_data_q;
    end else begin : g_no_out_reg
        assign rd_valid = s1_valid_q;
        assign rd_data  = s1_data_d;
    end

`ifndef SYNTHESIS
    // Simulation-only reporting of collisions and out-of-range accesses.
    always @(posedge clk) begin
        if (!rst) begin
            if (CollisionMode == COLL_REPORT) begin
                assert (!coll) else $error("ram_1c_1r_1w_pipe: read/write collision at address %0d", rd_addr);
            end
            assert (!(wr_en && !wr_in_range)) else $warning("ram_1c_1r_1w_pipe: write address %0d out of range", wr_addr);
            assert (!(rd_en && !rd_in_range)) else $warning("ram_1c_1r_1w_pipe: read address %0d out of range", rd_addr);
        end
    end
`endif

endmodule
